fp_divider: RTL and testbench

- Sequential IEEE-754 single-precision divider, the inverse operation of the team's combinational FP multiplier.
- Computes quot = dividend / divisor by radix-2 restoring division on the 24-bit significands, one quotient bit per clock.
- Uses a start/done handshake and a fixed latency.
- Uses the same number model as the multiplier: normalized operands only, truncation (no rounding), plus overflow and underflow flags.
- Sits beside the multiplier in the ALU datapath and adds a divide-by-zero flag.

---
 rtl/fp_divider.sv | 164 ++++++++++++++++
 tb/tb_fp_divider.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_divider.sv
// Sequential IEEE-754 single-precision divider.
// Radix-2 restoring division on the 24-bit significands, one quotient bit
// per clock, followed by a single normalization/packing cycle. Normalized
// operands only, truncated result, overflow/underflow/divide-by-zero flags.
// Handshake: start is sampled only in IDLE; busy is high from the accepting
// edge until done; done is a one-cycle pulse after which quot and the flags
// stay valid until the next operation completes its NORM cycle.
module fp_divider #(
   parameter int QBITS = 25
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [31:0] dividend,
   input  logic [31:0] divisor,
   output logic        busy,
   output logic        done,
   output logic [31:0] quot,
   output logic        overflow,
   output logic        underflow,
   output logic        div_by_zero
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      DIV  = 2'd1,
      NORM = 2'd2,
      DONE = 2'd3
   } state_t;

   localparam logic [4:0] LAST_BIT = 5'(QBITS - 1);

   state_t      state;
   state_t      state_nxt;

   logic        sign;
   logic [7:0]  e1;
   logic [7:0]  e2;
   logic [25:0] rem;
   logic [23:0] dvs;
   logic [24:0] q;
   logic [4:0]  cnt;

   logic [25:0]       diff;
   logic [22:0]       mant;
   logic              adj;
   logic signed [9:0] exp_s;
   logic [31:0]       res_quot;
   logic              res_ovf;
   logic              res_unf;
   logic              res_dbz;

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // Next-state logic: fixed sequence, DIV lasts exactly QBITS cycles
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = DIV;
         DIV:     if (cnt == LAST_BIT) state_nxt = NORM;
         NORM:    state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Handshake outputs decoded from state
   always_comb begin
      busy = (state == DIV) || (state == NORM);
      done = (state == DONE);
   end

   // Trial subtraction; the remainder always stays below 2*D, so bit 25
   // is a clean sign bit for the 26-bit difference
   always_comb begin
      diff = rem - {2'b00, dvs};
   end

   // Normalization and special-case selection, consumed in NORM
   always_comb begin
      if (q[QBITS-1]) begin
         mant = q[23:1];
         adj  = 1'b0;
      end else begin
         mant = q[22:0];
         adj  = 1'b1;
      end
      exp_s = $signed({2'b00, e1}) - $signed({2'b00, e2}) + 10'sd127
              - $signed({9'd0, adj});
      res_ovf = 1'b0;
      res_unf = 1'b0;
      res_dbz = 1'b0;
      if (e2 == 8'd0 && e1 == 8'd0) begin
         res_quot = 32'h7FC0_0000;
         res_dbz  = 1'b1;
      end else if (e2 == 8'd0) begin
         res_quot = {sign, 8'hFF, 23'h0};
         res_dbz  = 1'b1;
      end else if (e1 == 8'd0) begin
         res_quot = {sign, 31'h0};
      end else if (exp_s >= 10'sd255) begin
         res_quot = {sign, 8'hFF, 23'h0};
         res_ovf  = 1'b1;
      end else if (exp_s <= 10'sd0) begin
         res_quot = {sign, 31'h0};
         res_unf  = 1'b1;
      end else begin
         res_quot = {sign, exp_s[7:0], mant};
      end
   end

   // Datapath: operand capture, one restoring step per DIV cycle, result load
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sign        <= 1'b0;
         e1          <= 8'd0;
         e2          <= 8'd0;
         rem         <= 26'd0;
         dvs         <= 24'd0;
         q           <= 25'd0;
         cnt         <= 5'd0;
         quot        <= 32'h0;
         overflow    <= 1'b0;
         underflow   <= 1'b0;
         div_by_zero <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  sign <= dividend[31] ^ divisor[31];
                  e1   <= dividend[30:23];
                  e2   <= divisor[30:23];
                  rem  <= {2'b01, dividend[22:0]};
                  dvs  <= {1'b1, divisor[22:0]};
                  q    <= 25'd0;
                  cnt  <= 5'd0;
               end
            end
            DIV: begin
               if (!diff[25]) begin
                  rem <= {diff[24:0], 1'b0};
                  q   <= {q[QBITS-2:0], 1'b1};
               end else begin
                  rem <= {rem[24:0], 1'b0};
                  q   <= {q[QBITS-2:0], 1'b0};
               end
               cnt <= cnt + 5'd1;
            end
            NORM: begin
               quot        <= res_quot;
               overflow    <= res_ovf;
               underflow   <= res_unf;
               div_by_zero <= res_dbz;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_fp_divider.sv
// Bench for fp_divider: directed cases, handshake corner cases, reset abort
// and randomized operands against a plain-arithmetic reference model.
// Stimulus pushes expectations into a queue; a negedge monitor pops and
// compares whenever done is seen.
module tb_fp_divider;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic [31:0] dividend = 32'h0;
   logic [31:0] divisor = 32'h0;
   logic        busy;
   logic        done;
   logic [31:0] quot;
   logic        overflow;
   logic        underflow;
   logic        div_by_zero;

   fp_divider dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start),
      .dividend    (dividend),
      .divisor     (divisor),
      .busy        (busy),
      .done        (done),
      .quot        (quot),
      .overflow    (overflow),
      .underflow   (underflow),
      .div_by_zero (div_by_zero)
   );

   // clock / reset block
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic [34:0] exp_q[$];   // {quot, overflow, underflow, div_by_zero}
   int          acc_q[$];   // cycle count at the accepting edge
   int          n_checks = 0;
   int          n_fail = 0;
   int          done_cnt = 0;
   logic        prev_done = 1'b0;
   logic [34:0] last_exp = '0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // reference model: real-number division semantics via integer arithmetic
   function automatic logic [34:0] ref_div(input logic [31:0] a, input logic [31:0] b);
      longint e1 = longint'(a[30:23]);
      longint e2 = longint'(b[30:23]);
      longint n = longint'({1'b1, a[22:0]}) << 24;
      longint d = longint'({1'b1, b[22:0]});
      longint qv = n / d;
      longint mant;
      longint adj;
      longint e;
      logic   s = a[31] ^ b[31];
      logic [7:0]  eb;
      logic [22:0] mb;
      if (qv >= (longint'(1) << 24)) begin
         mant = (qv >> 1) & 'h7FFFFF;
         adj  = 0;
      end else begin
         mant = qv & 'h7FFFFF;
         adj  = 1;
      end
      e  = e1 - e2 + 127 - adj;
      eb = 8'(e);
      mb = 23'(mant);
      if (e1 == 0 && e2 == 0) return {32'h7FC00000, 3'b001};
      if (e2 == 0)            return {s, 8'hFF, 23'h0, 3'b001};
      if (e1 == 0)            return {s, 31'h0, 3'b000};
      if (e >= 255)           return {s, 8'hFF, 23'h0, 3'b100};
      if (e <= 0)             return {s, 31'h0, 3'b010};
      return {s, eb, mb, 3'b000};
   endfunction

   // monitor / scoreboard
   always @(negedge clk) begin
      logic [34:0] e;
      int          a;
      if (done) begin
         done_cnt++;
         check("done_width", 64'(prev_done), 64'd0);
         if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_done: got done=1 expected no pending op (t=%0t)", $time);
         end else begin
            e = exp_q.pop_front();
            a = acc_q.pop_front();
            check("quot", 64'(quot), 64'(e[34:3]));
            check("flags", 64'({overflow, underflow, div_by_zero}), 64'(e[2:0]));
            check("latency", 64'(cyc - a), 64'd26);
            check("busy_at_done", 64'(busy), 64'd0);
         end
      end
      prev_done = done;
   end

   // driver tasks
   task automatic wait_idle();
      int t = 0;
      while ((busy || done) && t < 100) begin
         @(negedge clk);
         t++;
      end
      if (t >= 100) begin
         n_checks++;
         n_fail++;
         $display("FAIL idle_timeout: got busy=%0b done=%0b expected idle", busy, done);
      end
   endtask

   task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [34:0] exp);
      wait_idle();
      dividend = a;
      divisor  = b;
      start    = 1'b1;
      @(posedge clk);
      #1;
      exp_q.push_back(exp);
      acc_q.push_back(cyc);
      last_exp = exp;
      check("busy_after_accept", 64'(busy), 64'd1);
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_done();
      int t = 0;
      @(negedge clk);
      while (!done && t < 40) begin
         @(negedge clk);
         t++;
      end
      if (t >= 40) begin
         n_checks++;
         n_fail++;
         $display("FAIL done_timeout: got done=0 expected done within 40 cycles");
      end
   endtask

   task automatic drain();
      int t = 0;
      while (exp_q.size() > 0 && t < 200) begin
         @(negedge clk);
         t++;
      end
      if (exp_q.size() > 0) begin
         n_checks++;
         n_fail++;
         $display("FAIL drain: got %0d pending expected 0", exp_q.size());
      end
   endtask

   // watchdog
   initial begin
      #2000000;
      $display("FAIL watchdog: got no finish expected finish before time limit");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int base;
      logic [31:0] r1;
      logic [31:0] r2;
      logic [7:0]  ea;
      logic [7:0]  eb;
      logic [31:0] a;
      logic [31:0] b;

      // reset state
      repeat (3) @(negedge clk);
      check("rst_quot", 64'(quot), 64'h0);
      check("rst_flags", 64'({overflow, underflow, div_by_zero}), 64'd0);
      check("rst_busy_done", 64'({busy, done}), 64'd0);
      rst_n = 1'b1;
      @(negedge clk);

      // directed cases
      issue(32'h40C00000, 32'h40000000, {32'h40400000, 3'b000});
      issue(32'h3F800000, 32'h40400000, {32'h3EAAAAAA, 3'b000});
      issue(32'hBFC00000, 32'h3F000000, {32'hC0400000, 3'b000});
      issue(32'h3F800000, 32'h00000000, {32'h7F800000, 3'b001});
      issue(32'h00000000, 32'h00000000, {32'h7FC00000, 3'b001});
      issue(32'h7F000000, 32'h3E800000, {32'h7F800000, 3'b100});
      issue(32'h00800000, 32'h40000000, {32'h00000000, 3'b010});
      issue(32'hC0C00000, 32'h80800000, ref_div(32'hC0C00000, 32'h80800000));
      drain();

      // start held during the DONE cycle is taken only in the following IDLE cycle
      issue(32'h40C00000, 32'h40000000, {32'h40400000, 3'b000});
      wait_done();
      dividend = 32'h3F800000;
      divisor  = 32'h40400000;
      start    = 1'b1;
      @(posedge clk);
      @(posedge clk);
      #1;
      exp_q.push_back({32'h3EAAAAAA, 3'b000});
      acc_q.push_back(cyc);
      last_exp = {32'h3EAAAAAA, 3'b000};
      @(negedge clk);
      start = 1'b0;
      drain();

      // start while busy is ignored and busy stays high
      issue(32'h40C00000, 32'h40000000, {32'h40400000, 3'b000});
      for (int i = 1; i <= 25; i++) begin
         if (i == 10) begin
            dividend = 32'h3F800000;
            divisor  = 32'h40400000;
            start    = 1'b1;
         end
         if (i == 11) start = 1'b0;
         check("busy_hold", 64'(busy), 64'd1);
         @(negedge clk);
      end
      drain();

      // reset mid-operation aborts without done
      issue(32'h40C00000, 32'h40000000, {32'h40400000, 3'b000});
      repeat (11) @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check("abort_quot", 64'(quot), 64'h0);
      check("abort_outputs", 64'({busy, done, overflow, underflow, div_by_zero}), 64'd0);
      exp_q.delete();
      acc_q.delete();
      base = done_cnt;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (30) @(negedge clk);
      check("no_done_after_abort", 64'(done_cnt - base), 64'd0);
      issue(32'h3F800000, 32'h40400000, {32'h3EAAAAAA, 3'b000});
      drain();

      // randomized operands
      for (int i = 0; i < 40; i++) begin
         r1 = $urandom();
         r2 = $urandom();
         ea = ($urandom_range(0, 9) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
         eb = ($urandom_range(0, 9) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
         a  = {r1[31], ea, r1[22:0]};
         b  = {r2[31], eb, r2[22:0]};
         issue(a, b, ref_div(a, b));
      end
      drain();

      // result held after completion
      repeat (3) @(negedge clk);
      check("quot_held", 64'(quot), 64'(last_exp[34:3]));
      check("flags_held", 64'({overflow, underflow, div_by_zero}), 64'(last_exp[2:0]));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
